// File: rtl/node_scan_ctrl.sv
// Neighbour scan: compares a node's value against four masked neighbours using one shared comparator.
// Latency: capture at start edge, one neighbour per edge; done asserts the cycle after the last evaluation.
// Backpressure: none; start is ignored unless idle, abort cancels a scan in flight without a done pulse.
module node_scan_ctrl #(
    parameter int CMP_MODE   = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] self_val,
    input  logic [1:0] nb0,
    input  logic [1:0] nb1,
    input  logic [1:0] nb2,
    input  logic [1:0] nb3,
    input  logic [3:0] nb_en,
    output logic       busy,
    output logic       done,
    output logic       out,
    output logic [1:0] hit_idx,
    output logic [2:0] hit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;

    // Snapshot of the request; inputs may change freely once the scan starts.
    logic [1:0] cap_self;
    logic [1:0] cap_nb0;
    logic [1:0] cap_nb1;
    logic [1:0] cap_nb2;
    logic [1:0] cap_nb3;
    logic [3:0] cap_en;

    logic [1:0] idx;
    logic       acc_or;
    logic [2:0] acc_cnt;
    logic [1:0] acc_idx;

    logic [1:0] sel_nb;
    logic       cmp_hit;
    logic       hit;
    logic       nxt_or;
    logic [2:0] nxt_cnt;
    logic [1:0] nxt_idx;
    logic       last_eval;

    always_comb begin
        sel_nb = cap_nb0;
        case (idx)
            2'd0:    sel_nb = cap_nb0;
            2'd1:    sel_nb = cap_nb1;
            2'd2:    sel_nb = cap_nb2;
            default: sel_nb = cap_nb3;
        endcase
    end

    // The single comparator shared by every neighbour slot.
    always_comb begin
        cmp_hit = 1'b0;
        if (CMP_MODE == 1) begin
            cmp_hit = (cap_self == sel_nb);
        end else begin
            cmp_hit = (cap_self > sel_nb);
        end
    end

    always_comb begin
        hit       = cmp_hit & cap_en[idx];
        nxt_or    = acc_or | hit;
        nxt_cnt   = acc_cnt + {2'b00, hit};
        nxt_idx   = (hit && !acc_or) ? idx : acc_idx;
        last_eval = (idx == 2'd3) || ((EARLY_EXIT != 0) && hit);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= 1'b0;
            hit_idx  <= 2'd0;
            hit_cnt  <= 3'd0;
            cap_self <= 2'd0;
            cap_nb0  <= 2'd0;
            cap_nb1  <= 2'd0;
            cap_nb2  <= 2'd0;
            cap_nb3  <= 2'd0;
            cap_en   <= 4'd0;
            idx      <= 2'd0;
            acc_or   <= 1'b0;
            acc_cnt  <= 3'd0;
            acc_idx  <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cap_self <= self_val;
                        cap_nb0  <= nb0;
                        cap_nb1  <= nb1;
                        cap_nb2  <= nb2;
                        cap_nb3  <= nb3;
                        cap_en   <= nb_en;
                        idx      <= 2'd0;
                        acc_or   <= 1'b0;
                        acc_cnt  <= 3'd0;
                        acc_idx  <= 2'd0;
                        busy     <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        // Result registers keep the previous scan's outcome.
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc_or  <= nxt_or;
                        acc_cnt <= nxt_cnt;
                        acc_idx <= nxt_idx;
                        if (last_eval) begin
                            out     <= nxt_or;
                            hit_cnt <= nxt_cnt;
                            hit_idx <= nxt_idx;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_node_scan_ctrl.sv
// Bench for node_scan_ctrl: four parameter variants share one stimulus stream and are
// checked against a behavioural scan model.
module tb_node_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] self_val;
    logic [1:0] nb[4];
    logic [3:0] nb_en;

    logic       busy_w[4];
    logic       done_w[4];
    logic       out_w[4];
    logic [1:0] hidx_w[4];
    logic [2:0] hcnt_w[4];

    int n_checks = 0;
    int n_fail   = 0;

    // Captured request and observations of the last run_scan.
    logic [1:0] cap_s;
    logic [1:0] cap_v[4];
    logic [3:0] cap_en;
    int         lat_obs[4];
    int         done_cnt[4];
    logic       busy1[4];

    // Outputs each instance should still show when a scan does not complete.
    int prev_out[4];
    int prev_idx[4];
    int prev_cnt[4];

    always #5 clk = ~clk;

    // Instance i: CMP_MODE = i % 2, EARLY_EXIT = i / 2.
    node_scan_ctrl #(.CMP_MODE(0), .EARLY_EXIT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .self_val(self_val),
        .nb0(nb[0]), .nb1(nb[1]), .nb2(nb[2]), .nb3(nb[3]), .nb_en(nb_en),
        .busy(busy_w[0]), .done(done_w[0]), .out(out_w[0]), .hit_idx(hidx_w[0]), .hit_cnt(hcnt_w[0]));
    node_scan_ctrl #(.CMP_MODE(1), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .self_val(self_val),
        .nb0(nb[0]), .nb1(nb[1]), .nb2(nb[2]), .nb3(nb[3]), .nb_en(nb_en),
        .busy(busy_w[1]), .done(done_w[1]), .out(out_w[1]), .hit_idx(hidx_w[1]), .hit_cnt(hcnt_w[1]));
    node_scan_ctrl #(.CMP_MODE(0), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .self_val(self_val),
        .nb0(nb[0]), .nb1(nb[1]), .nb2(nb[2]), .nb3(nb[3]), .nb_en(nb_en),
        .busy(busy_w[2]), .done(done_w[2]), .out(out_w[2]), .hit_idx(hidx_w[2]), .hit_cnt(hcnt_w[2]));
    node_scan_ctrl #(.CMP_MODE(1), .EARLY_EXIT(1)) u3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .self_val(self_val),
        .nb0(nb[0]), .nb1(nb[1]), .nb2(nb[2]), .nb3(nb[3]), .nb_en(nb_en),
        .busy(busy_w[3]), .done(done_w[3]), .out(out_w[3]), .hit_idx(hidx_w[3]), .hit_cnt(hcnt_w[3]));

    // Reference: walk the neighbours in order; n = number of edges spent evaluating.
    function automatic void ref_scan(input int mode, input int early, input logic [1:0] s,
                                     input logic [1:0] v[4], input logic [3:0] en,
                                     output int o, output int idx, output int cnt, output int n);
        o = 0; idx = 0; cnt = 0; n = 4;
        for (int i = 0; i < 4; i++) begin
            bit h;
            h = en[i] && ((mode == 1) ? (s == v[i]) : (s > v[i]));
            if (h) begin
                if (cnt == 0) idx = i;
                cnt++;
                o = 1;
                if (early != 0) begin
                    n = i + 1;
                    break;
                end
            end
        end
    endfunction

    // Start a scan at edge E0, scramble inputs afterwards, re-pulse start at E2,
    // optionally abort at abort_edge, and record when each instance shows done.
    task automatic run_scan(input logic [1:0] s, input logic [1:0] a, input logic [1:0] b,
                            input logic [1:0] c, input logic [1:0] d, input logic [3:0] en,
                            input int abort_edge);
        @(negedge clk);
        self_val = s; nb[0] = a; nb[1] = b; nb[2] = c; nb[3] = d; nb_en = en;
        start = 1'b1; abort = 1'b0;
        cap_s = s; cap_v[0] = a; cap_v[1] = b; cap_v[2] = c; cap_v[3] = d; cap_en = en;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            lat_obs[i] = -1; done_cnt[i] = 0; busy1[i] = 1'b0;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start    = (k == 2);
            abort    = (k == abort_edge);
            self_val = 2'($urandom);
            for (int j = 0; j < 4; j++) nb[j] = 2'($urandom);
            nb_en = 4'($urandom);
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (k == 1) busy1[i] = busy_w[i];
                if (done_w[i]) begin
                    done_cnt[i]++;
                    if (lat_obs[i] < 0) lat_obs[i] = k;
                end
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b1; abort = 1'b1;
        self_val = 2'd3; nb_en = 4'hF;
        for (int j = 0; j < 4; j++) nb[j] = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy_w[i], done_w[i], out_w[i], hidx_w[i], hcnt_w[i]} !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: busy=%b done=%b out=%b idx=%0d cnt=%0d, required all 0",
                         i, busy_w[i], done_w[i], out_w[i], hidx_w[i], hcnt_w[i]);
            end
            prev_out[i] = 0; prev_idx[i] = 0; prev_cnt[i] = 0;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scans(input int n_random);
        logic [1:0] tbl_s[3]   = '{2'd3, 2'd2, 2'd2};
        logic [7:0] tbl_nb[3]  = '{8'b11_01_11_00, 8'b00_10_10_01, 8'b00_00_01_11};
        logic [3:0] tbl_en[3]  = '{4'b1111, 4'b1011, 4'b0000};
        for (int t = 0; t < 3 + n_random; t++) begin
            logic [1:0] s;
            logic [7:0] v;
            logic [3:0] en;
            if (t < 3) begin
                s = tbl_s[t]; v = tbl_nb[t]; en = tbl_en[t];
            end else begin
                s = 2'($urandom); v = 8'($urandom); en = 4'($urandom);
                if (t == 3) en = 4'b0000;
            end
            run_scan(s, v[1:0], v[3:2], v[5:4], v[7:6], en, 0);
            for (int i = 0; i < 4; i++) begin
                int eo, ei, ec, en_ev;
                ref_scan(i % 2, i / 2, cap_s, cap_v, cap_en, eo, ei, ec, en_ev);
                // done visible after edge E_n, so the edge sampling it is E_(n+1).
                n_checks++;
                if (lat_obs[i] + 1 != en_ev + 1) begin
                    n_fail++;
                    $display("FAIL scan%0d_latency inst%0d: done sampled %0d edges after start, required %0d",
                             t, i, lat_obs[i] + 1, en_ev + 1);
                end
                n_checks++;
                if (done_cnt[i] != 1) begin
                    n_fail++;
                    $display("FAIL scan%0d_done_pulses inst%0d: %0d cycles, required 1", t, i, done_cnt[i]);
                end
                n_checks++;
                if (busy1[i] !== (en_ev > 1)) begin
                    n_fail++;
                    $display("FAIL scan%0d_busy inst%0d: %b after E1, required %b", t, i, busy1[i], en_ev > 1);
                end
                n_checks++;
                if ({out_w[i], hidx_w[i], hcnt_w[i]} !== {1'(eo), 2'(ei), 3'(ec)}) begin
                    n_fail++;
                    $display("FAIL scan%0d_result inst%0d: out=%b idx=%0d cnt=%0d, required out=%0d idx=%0d cnt=%0d",
                             t, i, out_w[i], hidx_w[i], hcnt_w[i], eo, ei, ec);
                end
                prev_out[i] = eo; prev_idx[i] = ei; prev_cnt[i] = ec;
            end
        end
    endtask

    task automatic test_abort;
        // Seed known non-zero results, then abort the next scan at E2.
        run_scan(2'd3, 2'd0, 2'd3, 2'd1, 2'd3, 4'b1111, 0);
        for (int i = 0; i < 4; i++) begin
            int eo, ei, ec, en_ev;
            ref_scan(i % 2, i / 2, cap_s, cap_v, cap_en, eo, ei, ec, en_ev);
            prev_out[i] = eo; prev_idx[i] = ei; prev_cnt[i] = ec;
        end
        run_scan(2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 4'b1111, 2);
        for (int i = 0; i < 4; i++) begin
            int eo, ei, ec, en_ev;
            bit aborted;
            ref_scan(i % 2, i / 2, cap_s, cap_v, cap_en, eo, ei, ec, en_ev);
            aborted = (en_ev >= 2);
            n_checks++;
            if (done_cnt[i] != (aborted ? 0 : 1)) begin
                n_fail++;
                $display("FAIL abort_done inst%0d: %0d done cycles, required %0d", i, done_cnt[i], aborted ? 0 : 1);
            end
            if (!aborted) begin
                prev_out[i] = eo; prev_idx[i] = ei; prev_cnt[i] = ec;
            end
            n_checks++;
            if ({out_w[i], hidx_w[i], hcnt_w[i]} !== {1'(prev_out[i]), 2'(prev_idx[i]), 3'(prev_cnt[i])}) begin
                n_fail++;
                $display("FAIL abort_hold inst%0d: out=%b idx=%0d cnt=%0d, required out=%0d idx=%0d cnt=%0d",
                         i, out_w[i], hidx_w[i], hcnt_w[i], prev_out[i], prev_idx[i], prev_cnt[i]);
            end
            n_checks++;
            if (busy_w[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle inst%0d: busy=%b, required 0", i, busy_w[i]);
            end
        end
    endtask

    task automatic test_reset_midscan;
        int seen_done;
        @(negedge clk);
        self_val = 2'd3; nb_en = 4'hF; start = 1'b1;
        for (int j = 0; j < 4; j++) nb[j] = 2'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy_w[i], done_w[i], out_w[i], hidx_w[i], hcnt_w[i]} !== 8'd0) begin
                n_fail++;
                $display("FAIL midscan_reset inst%0d: busy=%b done=%b out=%b idx=%0d cnt=%0d, required all 0",
                         i, busy_w[i], done_w[i], out_w[i], hidx_w[i], hcnt_w[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        seen_done = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) seen_done += done_w[i];
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL midscan_no_done: %0d done cycles after reset, required 0", seen_done);
        end
        run_scan(2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 4'b1110, 0);
        for (int i = 0; i < 4; i++) begin
            int eo, ei, ec, en_ev;
            ref_scan(i % 2, i / 2, cap_s, cap_v, cap_en, eo, ei, ec, en_ev);
            n_checks++;
            if (lat_obs[i] != en_ev || {out_w[i], hidx_w[i], hcnt_w[i]} !== {1'(eo), 2'(ei), 3'(ec)}) begin
                n_fail++;
                $display("FAIL post_reset_scan inst%0d: done after E%0d out=%b idx=%0d cnt=%0d, required E%0d out=%0d idx=%0d cnt=%0d",
                         i, lat_obs[i], out_w[i], hidx_w[i], hcnt_w[i], en_ev, eo, ei, ec);
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        self_val = 2'd0; nb_en = 4'd0;
        for (int j = 0; j < 4; j++) nb[j] = 2'd0;
        test_reset();
        test_scans(40);
        test_abort();
        test_reset_midscan();
        test_scans(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/node_scan_ctrl.md
NODE_SCAN_CTRL -- requirements
Module: node_scan_ctrl

Interface
REQ-001 SHALL provide parameter CMP_MODE, default 0, compare rule: 0 = hit when self > neighbour, 1 = hit when self == neighbour (unsigned 2-bit).
REQ-002 SHALL provide parameter EARLY_EXIT, default 0, meaning 1 = terminate scan on first hit.
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port start  input  1  request a scan; sampled only in IDLE.
REQ-006 SHALL provide port abort  input  1  synchronous cancel of a scan in progress.
REQ-007 SHALL provide port self_val  input  2  node's own value.
REQ-008 SHALL provide ports nb0, nb1, nb2, nb3  input  2 each  neighbour values.
REQ-009 SHALL provide port nb_en  input  4  per-neighbour enable mask; bit i qualifies nb i.
REQ-010 SHALL provide port busy  output  1  high while in SCAN.
REQ-011 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-012 SHALL provide port out  output  1  OR of all hits from last completed scan.
REQ-013 SHALL provide port hit_idx  output  2  lowest neighbour index that hit; 0 if none.
REQ-014 SHALL provide port hit_cnt  output  3  number of hits, 0..4.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE; one shared 2-bit comparator, one neighbour evaluated per cycle.
REQ-016 IDLE: start=1 at edge E0 SHALL capture self_val, nb0..nb3, nb_en into internal registers, clear scan accumulators, set idx=0, go to SCAN.
REQ-017 SCAN: each edge SHALL evaluate captured neighbour idx; hit = comparator result AND captured nb_en[idx].
REQ-018 Accumulators: acc_or |= hit; acc_cnt += hit (3-bit, max 4, no wrap); first hit SHALL latch idx into acc_idx.
REQ-019 With EARLY_EXIT=0, evaluations SHALL occur at E1..E4 for idx 0..3; at E4 go to DONE; idx SHALL not wrap past 3.
REQ-020 With EARLY_EXIT=1, the edge evaluating a hit SHALL go to DONE; hit_cnt then reports 1.
REQ-021 On the edge entering DONE, out, hit_idx, hit_cnt SHALL load from accumulators including that edge's evaluation.
REQ-022 done SHALL be 1 exactly during the DONE cycle; DONE SHALL return to IDLE at the next edge unconditionally.
REQ-023 busy SHALL be 1 exactly while state is SCAN; latency start-edge to done-high = 5 cycles (EARLY_EXIT=0).
REQ-024 start while busy or in DONE SHALL be ignored, not queued.
REQ-025 Input changes after E0 SHALL not affect the scan in progress.
REQ-026 abort=1 in SCAN SHALL go to IDLE next edge, no done pulse, out/hit_idx/hit_cnt unchanged from prior scan; abort in IDLE/DONE SHALL be ignored.
REQ-027 abort and start asserted together in IDLE: start SHALL win.
REQ-028 nb_en=0000 SHALL yield out=0, hit_cnt=0, hit_idx=0 after full scan.
REQ-029 Outputs out, hit_idx, hit_cnt SHALL hold between scans.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, busy=0, done=0, out=0, hit_idx=0, hit_cnt=0, clear accumulators and idx; reset SHALL override start and abort.
REQ-031 rst=0 mid-scan SHALL discard the scan with no done pulse.

Verification
REQ-032 CMP_MODE=0: self=3, nb=(0,3,1,3), nb_en=1111, start -> done 5 cycles later, out=1, hit_cnt=2, hit_idx=0.
REQ-033 CMP_MODE=1: self=2, nb=(1,2,2,0), nb_en=1011 -> out=1, hit_cnt=1, hit_idx=1 (nb2 masked).
REQ-034 nb_en=0000, any values -> out=0, hit_cnt=0, hit_idx=0, done after 5 cycles.
REQ-035 EARLY_EXIT=1, CMP_MODE=0, self=2, nb=(3,1,0,0) -> done 3 cycles after start edge, hit_idx=1, hit_cnt=1.
REQ-036 start at E0, abort at E2 -> IDLE at E2, no done, outputs keep previous values; start during SCAN ignored.
REQ-037 rst=0 at E2 during a scan -> all outputs 0 next cycle, new start afterwards completes normally.
